// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up at the end, result held with a ready flag until start drops.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WR_W   = 2 * DATA_W + 1;
  localparam int unsigned CNT_W  = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WR_W-1:0]     wr_q, wr_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   quot_abs, rem_abs;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  // Operand magnitudes used at capture time
  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? DATA_W'(-opdata1_i) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? DATA_W'(-opdata2_i) : opdata2_i;
  end

  // Trial subtraction of the partial remainder and sign-corrected outputs
  always_comb begin
    diff     = {1'b0, wr_q[2*DATA_W-1:DATA_W]} - {1'b0, dvs_q};
    quot_abs = wr_q[DATA_W-1:0];
    rem_abs  = wr_q[WR_W-1:DATA_W+1];
    quot_fix = neg_quot_q ? DATA_W'(-quot_abs) : quot_abs;
    rem_fix  = neg_rem_q  ? DATA_W'(-rem_abs)  : rem_abs;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_o;
    ready_d    = ready_o;

    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          dvs_d      = op2_abs;
          neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d  = signed_div_i & opdata1_i[DATA_W-1];
          wr_d       = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          cnt_d      = '0;
          state_d    = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == LAST_ITER) begin
          state_d  = S_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end else begin
          // Restoring step: keep the difference only when it did not borrow
          if (!diff[DATA_W]) begin
            wr_d = {diff[DATA_W-1:0], wr_q[DATA_W-1:0], 1'b1};
          end else begin
            wr_d = {wr_q[WR_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      wr_q       <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_o   <= result_d;
      ready_o    <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random divides
// compared against plain-arithmetic quotient/remainder.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic, remainder follows dividend
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qb, rb;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q  = sa / sb;
    r  = sa % sb;
    qb = q;
    rb = r;
    return {rb[31:0], qb[31:0]};
  endfunction

  // Full transaction; operands are scrambled once captured
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int n;
    int lat;
    lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    annul      = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
    while (n < 100) begin
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = 1'($urandom % 2);
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
    end
    check({tag, ".latency"}, 64'(n), 64'(lat));
    check({tag, ".result"}, result, exp);
    @(posedge clk);
    #1;
    check({tag, ".hold"}, {63'd0, ready} ^ result, 64'd1 ^ exp);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".drop"}, {63'd0, ready} | result, 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic seen;
    logic        sgn;
    logic [31:0] a, b;

    rst = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
    #2;
    check("reset.ready", {63'd0, ready}, 64'd0);
    check("reset.result", result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14});
    run_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("u5_0",     1'b0, 32'd5,          32'd0,          64'd0);
    run_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000});
    run_div("uffff_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF});
    run_div("s-5_0",    1'b1, 32'hFFFF_FFFB,  32'd0,          64'd0);
    run_div("u_big",    1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  {32'h7FFF_FFFF, 32'd1});

    // Annul at edge 10 of ON
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1; annul = 1'b0;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul.ready", {63'd0, ready}, 64'd0);
    check("annul.result", result, 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready || result != 64'd0) seen = 1'b1;
    end
    check("annul.quiet", {63'd0, seen}, 64'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Start with annul held in FREE starts nothing
    @(negedge clk);
    opdata1 = 32'd8; opdata2 = 32'd2; start = 1'b1; annul = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check("free_annul.quiet", {63'd0, seen}, 64'd0);
    run_div("u8_2", 1'b0, 32'd8, 32'd2, {32'd0, 32'd4});

    // Reset at edge 20 of ON
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_on.ready", {63'd0, ready}, 64'd0);
    check("rst_on.result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_on.after", {63'd0, ready}, 64'd0);
    run_div("u50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10});

    // Reset while holding a result must clear it without a clock edge
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    check("rst_end.before", result, {32'd2, 32'd14});
    #2;
    rst = 1'b0;
    #1;
    check("rst_end.ready", {63'd0, ready}, 64'd0);
    check("rst_end.result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom % 2);
      a   = $urandom;
      case ($urandom % 5)
        0: b = $urandom;
        1: b = 32'($urandom % 16);
        2: b = 32'(-32'($urandom % 16));
        3: b = ($urandom % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        default: b = 32'($urandom % 65536);
      endcase
      if ($urandom % 8 == 0) a = 32'h8000_0000;
      run_div($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
